// File: rtl/serial_subtractor_ctrl.sv
// Serial subtractor sequencer: D = A - B - BIN using one SLICE-bit slice, LSB slice first.
// Latency: WIDTH/SLICE RUN cycles after the accepting edge, then a one-cycle DONE pulse.
// Backpressure: start is only taken while ready=1; starts during RUN are dropped, abort cancels RUN.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;

   logic             accept;
   logic             step;
   logic [SLICE:0]   slice_res;
   logic             brw_n;
   logic [WIDTH-1:0] res_next;

   // An accepted start can arrive in IDLE or in the DONE cycle (back-to-back).
   assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
   // A slice is consumed on every RUN edge unless the operation is being cancelled.
   assign step   = (state_q == S_RUN) && !abort;

   // One slice of the ripple subtractor; the extra MSB is the borrow out of this slice.
   assign slice_res = {1'b0, a_sh_q[SLICE-1:0]} - {1'b0, b_sh_q[SLICE-1:0]}
                      - {{SLICE{1'b0}}, brw_q};
   assign brw_n     = slice_res[SLICE];

   // New slice result enters the result shifter at the top, so after N slices it is aligned.
   generate
      if (N > 1) begin : g_multi
         assign res_next = {slice_res[SLICE-1:0], res_q[WIDTH-1:SLICE]};
      end else begin : g_single
         assign res_next = slice_res[SLICE-1:0];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort outranks the last-slice exit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN: begin
            if (abort)               state_d = S_IDLE;
            else if (cnt_q == LAST)  state_d = S_DONE;
         end
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      ready = (state_q == S_IDLE) || (state_q == S_DONE);
      busy  = (state_q == S_RUN);
      done  = (state_q == S_DONE);
   end

   // Datapath next-state: load on accept, shift per slice, publish results on the last slice.
   always_comb begin
      cnt_d  = cnt_q;
      a_sh_d = a_sh_q;
      b_sh_d = b_sh_q;
      brw_d  = brw_q;
      res_d  = res_q;
      diff_d = diff_q;
      bout_d = bout_q;
      zero_d = zero_q;
      if (accept) begin
         a_sh_d = a;
         b_sh_d = b;
         brw_d  = bin;
         cnt_d  = '0;
      end else if (step) begin
         a_sh_d = a_sh_q >> SLICE;
         b_sh_d = b_sh_q >> SLICE;
         brw_d  = brw_n;
         res_d  = res_next;
         cnt_d  = cnt_q + CW'(1);
         if (cnt_q == LAST) begin
            diff_d = res_next;
            bout_d = brw_n;
            zero_d = (res_next == '0);
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         a_sh_q <= '0;
         b_sh_q <= '0;
         brw_q  <= 1'b0;
         res_q  <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_sh_q <= a_sh_d;
         b_sh_q <= b_sh_d;
         brw_q  <= brw_d;
         res_q  <= res_d;
         diff_q <= diff_d;
         bout_q <= bout_d;
         zero_q <= zero_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized operations at 16/4 and 32/8 against a whole-word arithmetic reference.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start, abort, bin;
   logic [15:0] a, b;
   logic        ready, busy, done, bout, zero;
   logic [15:0] diff;

   logic        start32, abort32, bin32;
   logic [31:0] a32, b32;
   logic        ready32, busy32, done32, bout32, zero32;
   logic [31:0] diff32;

   serial_subtractor_ctrl #(.WIDTH(16), .SLICE(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a(a), .b(b), .bin(bin),
      .ready(ready), .busy(busy), .done(done),
      .diff(diff), .bout(bout), .zero(zero)
   );

   serial_subtractor_ctrl #(.WIDTH(32), .SLICE(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort32),
      .a(a32), .b(b32), .bin(bin32),
      .ready(ready32), .busy(busy32), .done(done32),
      .diff(diff32), .bout(bout32), .zero(zero32)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        bo;
      logic        z;
   } vec_t;

   vec_t vecs[8];

   // One operation on the 16-bit unit; caller is at a falling edge, returns one cycle after DONE.
   task automatic run16(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                        input logic ab_acc, input logic [15:0] ed, input logic eb,
                        input logic ez, input string tag);
      int lat;
      int nbusy;
      start = 1'b1; a = va; b = vb; bin = vbin; abort = ab_acc;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      lat = 1; nbusy = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd5);
      chk({tag, " busy cycles"}, 64'(nbusy), 64'd4);
      chk({tag, " diff"}, 64'(diff), 64'(ed));
      chk({tag, " bout"}, 64'(bout), 64'(eb));
      chk({tag, " zero"}, 64'(zero), 64'(ez));
      chk({tag, " ready/busy in done"}, 64'({ready, busy}), 64'b10);
      @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ndone, d1, d2;
      logic [15:0] e16d;
      logic        e16b, e16z;
      logic [31:0] e32d;
      logic        e32b, e32z;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; bin = 1'b0;
      start32 = 1'b0; abort32 = 1'b0; a32 = '0; b32 = '0; bin32 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset ready/busy/done", 64'({ready, busy, done}), 64'b100);
      chk("reset diff/bout/zero", 64'({diff, bout, zero}), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table: spec examples plus cross-slice borrow and wrap boundaries.
      vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[3] = '{16'h00F0, 16'h00F0, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1};
      vecs[6] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
      vecs[7] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         run16(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, vecs[i].d, vecs[i].bo, vecs[i].z,
               $sformatf("vec%0d", i));
      end

      // Abort while idle has no effect on an accepted start.
      run16(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, "abort-at-accept");

      // Start held high with operands changing: only sampled at accept, back-to-back in DONE.
      start = 1'b1; a = 16'h1234; b = 16'h0234; bin = 1'b0;
      ndone = 0; d1 = 0; d2 = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (d1 == 0) d1 = c;
            else if (d2 == 0) d2 = c;
         end
         if (c == 5) begin
            chk("b2b first diff", 64'(diff), 64'h1000);
            a = 16'h0000; b = 16'h0001; bin = 1'b0;
         end else begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         end
         if (c == 6) start = 1'b0;
         if (c == 7) chk("b2b diff held during run", 64'(diff), 64'h1000);
         if (c == 10) chk("b2b second result", 64'({bout, diff}), 64'h1FFFF);
      end
      chk("b2b done count", 64'(ndone), 64'd2);
      chk("b2b first done cycle", 64'(d1), 64'd5);
      chk("b2b done spacing", 64'(d2 - d1), 64'd5);

      // Abort in RUN cycle 3, then on the last slice: no done, prior result kept.
      run16(16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "pre-abort");
      for (int k = 3; k <= 4; k++) begin
         start = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b0;
         @(negedge clk);
         start = 1'b0;
         for (int c = 1; c < k; c++) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         chk($sformatf("abort%0d idle", k), 64'({ready, busy, done}), 64'b100);
         ndone = 0;
         repeat (6) begin
            if (done) ndone++;
            @(negedge clk);
         end
         chk($sformatf("abort%0d no done", k), 64'(ndone), 64'd0);
         chk($sformatf("abort%0d result held", k), 64'({bout, zero, diff}), 64'h1000);
      end

      // Asynchronous reset in the middle of RUN.
      start = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun reset ready/busy/done", 64'({ready, busy, done}), 64'b100);
      chk("midrun reset outputs", 64'({bout, zero, diff}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run16(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'h9998, 1'b0, 1'b0, "post-reset");

      // Randomized operations on both widths with occasional aborts.
      e16d = 16'h9998; e16b = 1'b0; e16z = 1'b0;
      e32d = '0; e32b = 1'b0; e32z = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         logic [16:0] r16;
         logic [32:0] r32;
         logic        ab;
         int          kab, n16, n32, t16, t32;
         ab  = ($urandom_range(0, 7) == 0);
         kab = $urandom_range(1, 4);
         a = 16'(pick()); b = 16'(pick()); bin = 1'($urandom);
         a32 = pick(); b32 = pick(); bin32 = 1'($urandom);
         if (!ab) begin
            r16 = {1'b0, a} - {1'b0, b} - 17'(bin);
            r32 = {1'b0, a32} - {1'b0, b32} - 33'(bin32);
            e16d = r16[15:0]; e16b = r16[16]; e16z = (r16[15:0] == 16'h0);
            e32d = r32[31:0]; e32b = r32[32]; e32z = (r32[31:0] == 32'h0);
         end
         start = 1'b1; start32 = 1'b1;
         @(negedge clk);
         start = 1'b0; start32 = 1'b0;
         a = 16'($urandom); a32 = $urandom;
         n16 = 0; n32 = 0; t16 = 0; t32 = 0;
         for (int c = 1; c <= 7; c++) begin
            if (done) begin
               n16++; t16 = c;
               chk("rnd16 result", 64'({e16b, e16z, e16d}), 64'({bout, zero, diff}));
            end
            if (done32) begin
               n32++; t32 = c;
               chk("rnd32 result", 64'({e32b, e32z, e32d}), 64'({bout32, zero32, diff32}));
            end
            abort   = ab && (c == kab);
            abort32 = ab && (c == kab);
            @(negedge clk);
         end
         chk("rnd16 done count", 64'(n16), ab ? 64'd0 : 64'd1);
         chk("rnd32 done count", 64'(n32), ab ? 64'd0 : 64'd1);
         if (!ab) begin
            chk("rnd16 done cycle", 64'(t16), 64'd5);
            chk("rnd32 done cycle", 64'(t32), 64'd5);
         end
         chk("rnd16 held", 64'({bout, zero, diff}), 64'({e16b, e16z, e16d}));
         chk("rnd32 held", 64'({bout32, zero32, diff32}), 64'({e32b, e32z, e32d}));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
